shift_reg_seq: RTL
==================

Name: shift_reg_seq

Overview:
- Parametrised successor to the single-step load/shift register used in the Booth datapath.
- Adds direction, shift mode (logical/arithmetic/rotate), a captured shift-out bit (Booth Q-1) and a self-timed multi-shift sequence with a start/busy/done handshake.
- Single-step shifting is still available while idle.
- Sits between the Booth controller and the A/Q datapath registers.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- MAX_SHIFT, WIDTH, largest shift count per sequence; a larger count saturates to this value.
- CNT_W, $clog2(MAX_SHIFT+1), width of the count port and internal counter (localparam-style, derived).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_en  input  1  parallel load of d.
- d  input  WIDTH  parallel load data.
- shift_en  input  1  single shift this cycle (IDLE only).
- shift_in  input  1  serial fill bit for logical mode.
- dir  input  1  0 = right, 1 = left.
- mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (behaves as 00).
- start  input  1  begin a multi-shift sequence (IDLE only).
- count  input  CNT_W  number of shifts for the sequence.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse when the sequence completes.
- q  output  WIDTH  register contents.
- shift_out  output  1  last bit shifted out.

Behaviour:
- Reset (asynchronous, any time including mid-sequence):
  - q=0, shift_out=0, busy=0, done=0, counter=0, state IDLE.
- States: IDLE, RUN. All outputs are registered.
- IDLE priority: load_en > start > shift_en.
  - load_en: q<=d, shift_out<=0.
  - start: latch dir and mode. Latch count, saturated to MAX_SHIFT.
    - count==0: done<=1 at the same edge, stay IDLE, q unchanged.
    - count>0: busy<=1, go to RUN, remaining<=count.
  - shift_en: one shift using the live dir/mode.
- RUN:
  - One shift per cycle using the latched dir/mode; shift_in is sampled live each cycle.
  - remaining decrements by 1 per shift.
  - On the shift where remaining==1: busy<=0, done<=1, go to IDLE.
  - load_en, start and shift_en are ignored for the whole RUN.
- Timing: start sampled at edge E0; shifts at edges E1..EN.
  - busy is high from E0 to EN.
  - done is high for the single cycle after EN, when q holds the final value.
  - A new start is accepted at edge EN+1.
- done is high for exactly 1 cycle per start; it is never asserted by load_en or shift_en.
- Shift operations (s = shift_out update):
  - right logical: q<={shift_in,q[W-1:1]}, s<=q[0].
  - right arithmetic: q<={q[W-1],q[W-1:1]}, s<=q[0].
  - right rotate: q<={q[0],q[W-1:1]}, s<=q[0].
  - left logical: q<={q[W-2:0],shift_in}, s<=q[W-1].
  - left arithmetic: q<={q[W-2:0],1'b0}, s<=q[W-1].
  - left rotate: q<={q[W-2:0],q[W-1]}, s<=q[W-1].
- No operation active: q and shift_out hold.

Optional Feature:
- Macro: SHIFT_REG_SEQ_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit, registered).
  - zero==1 exactly when the next-state q is all zeros, so it is valid in the same cycle as q.
  - Reset value of zero is 1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Manual shift: reset, load 0xAA, mode 00, dir 0, shift_in 0, shift_en for 3 cycles -> q=0x15, shift_out=0, busy=0 and done=0 throughout.
- Arithmetic sequence: load 0xAA, start with count=3, mode 01, dir 0 -> busy high 3 cycles, q sequence 0xD5, 0xEA, 0xF5, done pulse 1 cycle, final shift_out=0.
- Rotate left: load 0x81, start count=1, mode 10, dir 1 -> q=0x03, shift_out=1, done 1 cycle after start. Count=0 -> done next cycle, busy never high, q=0x03 unchanged.
- Saturation and ignore rules (WIDTH=8): load 0xFF, start count=15, mode 00, dir 0, shift_in 0 -> exactly 8 shifts, q=0x00, shift_out=1. load_en with d=0x55 and start asserted during RUN are ignored.
- Reset mid-operation: start count=6, drop rst_n after 2 shifts -> q, shift_out, busy, done, zero-flag state all at reset values immediately. After release, load 0x0F then start count=4 mode 00 dir 0 -> q=0x00, correct done timing.
- Left logical with serial fill and zero flag (macro defined): load 0x00, shift_in 1, start count=8, mode 00, dir 1 -> q=0xFF, zero=0. With shift_in 0 and the same start -> q=0x00, zero=1 in the done cycle.

Source files
------------

// File: rtl/shift_reg_seq.sv
// shift_reg_seq
//   Parametrised load/shift register for the Booth A/Q datapath. Supports
//   parallel load, single-step shifts while idle, and a self-timed
//   multi-shift sequence with a start/busy/done handshake. The bit shifted
//   out by the most recent shift is kept in shift_out (Booth Q-1).
//
//   Optional feature macro: SHIFT_REG_SEQ_ZERO_FLAG_EN
//     When defined, adds a registered "zero" output that is high exactly when
//     q is all zeros (reset value 1).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   load_en    parallel load of d (IDLE, highest priority)
//   d          parallel load data
//   shift_en   single shift using live dir/mode (IDLE, lowest priority)
//   shift_in   serial fill bit for logical mode
//   dir        0 = right, 1 = left
//   mode       00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//   start      begin a multi-shift sequence (IDLE)
//   count      shifts per sequence, saturated to MAX_SHIFT
//   busy       sequence in progress
//   done       one-cycle pulse after the final shift of a sequence
//   q          register contents
//   shift_out  last bit shifted out
//   zero       (optional) q is all zeros
//
// States
//   IDLE | accepts load, start, single shift
//   RUN  | one shift per cycle with latched dir/mode until remaining hits 0

module shift_reg_seq #(
  parameter int WIDTH     = 8,
  parameter int MAX_SHIFT = WIDTH,
  parameter int CNT_W     = $clog2(MAX_SHIFT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] d,
  input  logic             shift_en,
  input  logic             shift_in,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             shift_out
`ifdef SHIFT_REG_SEQ_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [CNT_W-1:0] count_sat;
  logic             dir_l, dir_l_nxt;
  logic [1:0]       mode_l, mode_l_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             shift_out_nxt, busy_nxt, done_nxt;
  logic [WIDTH:0]   live_shift, seq_shift;

  // Returns {bit shifted out, shifted value}. Mode 11 falls into the
  // logical (default) branch.
  function automatic logic [WIDTH:0] shift_op(input logic [WIDTH-1:0] v,
                                               input logic             left,
                                               input logic [1:0]       m,
                                               input logic             fill);
    logic [WIDTH:0] r;
    if (!left) begin
      case (m)
        2'b01:   r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
        2'b10:   r = {v[0], v[0],       v[WIDTH-1:1]};
        default: r = {v[0], fill,       v[WIDTH-1:1]};
      endcase
    end else begin
      case (m)
        2'b01:   r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
        2'b10:   r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
        default: r = {v[WIDTH-1], v[WIDTH-2:0], fill};
      endcase
    end
    return r;
  endfunction

  assign count_sat  = (count > CNT_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : count;
  assign live_shift = shift_op(q, dir, mode, shift_in);
  assign seq_shift  = shift_op(q, dir_l, mode_l, shift_in);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      dir_l     <= 1'b0;
      mode_l    <= 2'b00;
      q         <= '0;
      shift_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SHIFT_REG_SEQ_ZERO_FLAG_EN
      zero      <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      dir_l     <= dir_l_nxt;
      mode_l    <= mode_l_nxt;
      q         <= q_nxt;
      shift_out <= shift_out_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
`ifdef SHIFT_REG_SEQ_ZERO_FLAG_EN
      zero      <= (q_nxt == '0);
`endif
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!load_en && start && (count_sat != '0)) state_nxt = RUN;
      RUN:  if (remaining == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of datapath and handshake outputs
  always_comb begin
    q_nxt         = q;
    shift_out_nxt = shift_out;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    remaining_nxt = remaining;
    dir_l_nxt     = dir_l;
    mode_l_nxt    = mode_l;
    case (state)
      IDLE: begin
        if (load_en) begin
          q_nxt         = d;
          shift_out_nxt = 1'b0;
        end else if (start) begin
          dir_l_nxt  = dir;
          mode_l_nxt = mode;
          if (count_sat == '0) begin
            done_nxt = 1'b1;
          end else begin
            busy_nxt      = 1'b1;
            remaining_nxt = count_sat;
          end
        end else if (shift_en) begin
          {shift_out_nxt, q_nxt} = live_shift;
        end
      end
      RUN: begin
        {shift_out_nxt, q_nxt} = seq_shift;
        remaining_nxt          = remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
